// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer: FSM encoding, width helpers and
// the default gate length.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_t;

    // 25 ms at 49.152 MHz
    localparam int DEFAULT_GATE_CYCLES = 1228800;

    function automatic int step_idx_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic int len_w(input int steps);
        return step_idx_w(steps) + 1;
    endfunction

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern store: one write port and one registered read port.
// A read and a write to the same entry in one cycle return the old contents.
module seq_pattern_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Memory array with read-before-write; contents deliberately survive reset
    always_ff @(posedge clock_in) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/step_sequencer.sv
// Tempo-driven step sequencer: walks a programmable pattern on each tick rise
// and drives note, gate and step strobe to the voice.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int STEPS       = 16,
    parameter int NOTE_W      = 7,
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic                         clock_in,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         play,
    input  logic                         stop,
    input  logic [len_w(STEPS)-1:0]      length,
    input  logic                         wr_en,
    input  logic [step_idx_w(STEPS)-1:0] wr_addr,
    input  logic [NOTE_W-1:0]            wr_note,
    input  logic                         wr_active,
    output logic [NOTE_W-1:0]            note_out,
    output logic                         gate,
    output logic [step_idx_w(STEPS)-1:0] step_idx,
    output logic                         step_strobe,
    output logic                         running
);

    localparam int IDX_W = step_idx_w(STEPS);
    localparam int LEN_W = len_w(STEPS);
    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES - 1);

    seq_state_t         state_r;
    logic               tick_q_r;
    logic               step_pend_r;
    logic [IDX_W-1:0]   pend_idx_r;
    logic [CNT_W-1:0]   gate_cnt_r;
    logic               retrig_r;

    logic               tick_rise_s;
    logic               start_s;
    logic [LEN_W-1:0]   eff_len_s;
    logic [LEN_W-1:0]   idx_inc_s;
    logic [IDX_W-1:0]   next_idx_s;
    logic [NOTE_W:0]    rd_data_s;

    // The step index is resolved in the tick-rise cycle so the RAM read lines up
    // with the step update one cycle later.
    seq_pattern_ram #(
        .DEPTH  (STEPS),
        .ADDR_W (IDX_W),
        .DATA_W (NOTE_W + 1)
    ) u_pattern_ram (
        .clock_in (clock_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  ({wr_active, wr_note}),
        .rd_addr  (next_idx_s),
        .rd_data  (rd_data_s)
    );

    // Tick edge detect, effective length and next-step index
    always_comb begin
        tick_rise_s = tick & ~tick_q_r;
        if ((length == {LEN_W{1'b0}}) || (length > LEN_W'(STEPS))) begin
            eff_len_s = LEN_W'(STEPS);
        end else begin
            eff_len_s = length;
        end
        idx_inc_s = {1'b0, step_idx} + LEN_W'(1);
        if (state_r == ST_ARMED) begin
            next_idx_s = {IDX_W{1'b0}};
        end else if (idx_inc_s >= eff_len_s) begin
            next_idx_s = {IDX_W{1'b0}};
        end else begin
            next_idx_s = idx_inc_s[IDX_W-1:0];
        end
        start_s = tick_rise_s & ~stop & (state_r != ST_IDLE);
    end

    // FSM, step index, gate timing and output registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            tick_q_r    <= 1'b0;
            step_pend_r <= 1'b0;
            pend_idx_r  <= {IDX_W{1'b0}};
            gate_cnt_r  <= {CNT_W{1'b0}};
            retrig_r    <= 1'b0;
            note_out    <= {NOTE_W{1'b0}};
            gate        <= 1'b0;
            step_idx    <= {IDX_W{1'b0}};
            step_strobe <= 1'b0;
            running     <= 1'b0;
        end else begin
            tick_q_r    <= tick;
            step_pend_r <= start_s;
            pend_idx_r  <= next_idx_s;
            step_strobe <= 1'b0;
            if (stop) begin
                state_r    <= ST_IDLE;
                running    <= 1'b0;
                step_idx   <= {IDX_W{1'b0}};
                gate       <= 1'b0;
                gate_cnt_r <= {CNT_W{1'b0}};
                retrig_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (play) begin
                            state_r <= ST_ARMED;
                            running <= 1'b1;
                        end
                    end
                    ST_ARMED, ST_RUN: begin
                        if (step_pend_r) begin
                            state_r <= ST_RUN;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase

                if (step_pend_r) begin
                    step_idx    <= pend_idx_r;
                    step_strobe <= 1'b1;
                    if (rd_data_s[NOTE_W]) begin
                        note_out <= rd_data_s[NOTE_W-1:0];
                        // A still-sounding gate is dropped for one cycle so the envelope retriggers
                        if (gate) begin
                            gate     <= 1'b0;
                            retrig_r <= 1'b1;
                        end else begin
                            gate       <= 1'b1;
                            gate_cnt_r <= GATE_LOAD;
                        end
                    end else begin
                        gate       <= 1'b0;
                        retrig_r   <= 1'b0;
                        gate_cnt_r <= {CNT_W{1'b0}};
                    end
                end else if (retrig_r) begin
                    gate       <= 1'b1;
                    gate_cnt_r <= GATE_LOAD;
                    retrig_r   <= 1'b0;
                end else if (gate) begin
                    if (gate_cnt_r == {CNT_W{1'b0}}) begin
                        gate <= 1'b0;
                    end else begin
                        gate_cnt_r <= gate_cnt_r - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
